adder_rr_scheduler: RTL and testbench
=====================================

Name: adder_rr_scheduler

Overview:
- Shares one 32-bit recursive-doubling adder core (A, B in; S, Ca out) among NREQ requesters.
- Round-robin arbitration selects one requester per cycle and registers its operands into the core.
- The result is returned with the requester ID over a valid/ready output with backpressure.
- Sits between multiple ALU/address-generation clients and the single adder instance. It is the adder's only driver.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, requester ID width; must equal clog2(NREQ).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  NREQ  per-requester request valid.
- req_a  in  NREQ*32  flattened operand A; requester i uses bits [32i+31:32i].
- req_b  in  NREQ*32  flattened operand B, same packing.
- req_ready  out  NREQ  one-hot (or zero) accept strobe.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer ready.
- out_sum  out  32  sum, equal to core S.
- out_carry  out  1  carry out, equal to core Ca.
- out_id  out  IDW  requester that issued this result.

Behaviour:
- Interface: one clock domain, clk; reset rst is synchronous and active-high.
- Reset values:
  - out_valid=0, out_sum=0, out_carry=0, out_id=0.
  - Operand registers = 0.
  - Round-robin pointer ptr=0, so requester 0 has highest priority.
  - req_ready=0 while rst is high.
- Slot-free condition: can_accept = ~out_valid | out_ready.
- Grant:
  - Among asserted req_valid bits, pick the first index at or after ptr, wrapping modulo NREQ.
  - req_ready[g]=1 only if can_accept. All other req_ready bits are 0.
  - req_ready is combinational from req_valid, ptr, out_valid and out_ready.
- Accept: when req_valid[g] & req_ready[g]:
  - Latch req_a[g] into op_a, req_b[g] into op_b, and g into id_q.
  - Set out_valid=1 on the next cycle.
  - Set ptr = (g+1) mod NREQ.
- No accept: ptr is unchanged.
- Latency: 1 cycle from accept to out_valid.
  - out_sum/out_carry come combinationally from the core, which is driven by op_a/op_b.
  - They are stable while out_valid=1.
- Output hold: while out_valid & ~out_ready, op_a, op_b and id_q are frozen and req_ready is all 0.
- Throughput: accept and output consumption in the same cycle is allowed. This gives one op per cycle, back-to-back.
- Drain: out_ready=1 with no req_valid → out_valid=0 next cycle. op_a, op_b and id_q keep their last values.
- Arithmetic: unsigned 32-bit sum modulo 2^32, with out_carry = bit 32. The core has no carry-in.
- Boundaries:
  - All req_valid=0 → no grant.
  - Single requester continuously valid → it gets every slot.
  - All valid → strict rotation 0,1,2,3,0,...
  - req_valid may drop without being granted; no stale grant is held.
  - rst mid-operation → pending result discarded (out_valid=0) next cycle and ptr=0. The requester must reissue.
- Two states: EMPTY (out_valid=0) and FULL (out_valid=1).
  - EMPTY→FULL on accept.
  - FULL→FULL on consume+accept, or on stall.
  - FULL→EMPTY on consume without accept.

Optional Feature:
- Macro: ADDER_STATS_EN.
- Defined:
  - Adds per-requester 16-bit saturating grant counters, incremented on each accept for that requester.
  - Added ports: stat_sel (in, IDW) and stat_count (out, 16), with stat_count = count[stat_sel] combinationally.
  - stat_clr (in, 1) synchronously zeroes all counters; clear wins over a same-cycle increment.
  - Counters reset to 0.
- Undefined: no counters, no stat ports; behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - ADD_W=32.
  - STAT_W=16.
  - The EMPTY/FULL state encoding.
- Sub-module rr_arbiter (NREQ):
  - Inputs: req vector, ptr, enable (can_accept).
  - Outputs: one-hot grant, encoded grant index, any_grant.
  - Purely combinational. ptr is owned by the scheduler.
- Adder core is instantiated unchanged inside adder_rr_scheduler.

Test Plan:
- Reset/idle: assert rst 2 cycles, then all req_valid=0 → out_valid=0, req_ready=0000, out_sum=0.
- Single op: req1 sends A=0xFFFFFFFF, B=0x00000001 → next cycle out_valid=1, out_sum=0x00000000, out_carry=1, out_id=1.
- Fairness: all 4 requesters valid for 8 cycles with out_ready=1 → grant order 0,1,2,3,0,1,2,3; one result per cycle; sums correct, e.g. A=0x12345678, B=0x11111111 → 0x23456789, carry 0.
- Backpressure: out_ready=0 for 3 cycles with a result pending → out_valid, out_sum and out_id stable, req_ready=0000; out_ready=1 → next queued requester accepted in the same cycle.
- Reset mid-op: result pending with out_ready=0, pulse rst → out_valid=0 next cycle and ptr=0; requesters 0 and 2 then valid → requester 0 granted first.
- ADDER_STATS_EN build: 5 grants to requester 2, stat_sel=2 → stat_count=5. Pulse stat_clr → 0. Preload count to 0xFFFF and grant → count stays 0xFFFF.

Source files
------------

// File: rtl/adder_rr_scheduler_pkg.sv
// Shared constants and the result-slot state encoding for adder_rr_scheduler.
package adder_rr_scheduler_pkg;

    localparam int ADD_W  = 32;  // adder datapath width
    localparam int STAT_W = 16;  // grant statistics counter width

    // The single result slot is either empty or holds an unconsumed sum.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/adder_rr_scheduler_if.sv
// Request/result bus between the adder clients and adder_rr_scheduler.
// The master side drives requests and the consumer ready; the slave side is the scheduler.
interface adder_rr_scheduler_if
    import adder_rr_scheduler_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
);

    logic [NREQ-1:0]       req_valid;
    logic [NREQ*ADD_W-1:0] req_a;
    logic [NREQ*ADD_W-1:0] req_b;
    logic [NREQ-1:0]       req_ready;
    logic                  out_valid;
    logic                  out_ready;
    logic [ADD_W-1:0]      out_sum;
    logic                  out_carry;
    logic [IDW-1:0]        out_id;

    modport master (
        output req_valid, req_a, req_b, out_ready,
        input  req_ready, out_valid, out_sum, out_carry, out_id
    );

    modport slave (
        input  req_valid, req_a, req_b, out_ready,
        output req_ready, out_valid, out_sum, out_carry, out_id
    );

endinterface

// File: rtl/adder_rr_scheduler_core.sv
// Recursive-doubling (Kogge-Stone) adder core: S = A + B, Ca = carry out, no carry-in.
module rd_adder32
    import adder_rr_scheduler_pkg::*;
(
    input  logic [ADD_W-1:0] a_i,
    input  logic [ADD_W-1:0] b_i,
    output logic [ADD_W-1:0] s_o,
    output logic             ca_o
);

    // Prefix tree: each level doubles the span of the generate/propagate pairs.
    always_comb begin
        logic [ADD_W-1:0] g;
        logic [ADD_W-1:0] p;
        logic [ADD_W-1:0] g_nx;
        logic [ADD_W-1:0] p_nx;
        logic [ADD_W-1:0] p0;
        // NOTE: combinational blocks use blocking '=' so each level reads the level just
        // computed above it; clocked blocks use '<=' so all flops update together.
        g  = a_i & b_i;
        p  = a_i ^ b_i;
        p0 = p;
        for (int k = 0; (1 << k) < ADD_W; k++) begin
            g_nx = g;
            p_nx = p;
            for (int i = (1 << k); i < ADD_W; i++) begin
                g_nx[i] = g[i] | (p[i] & g[i - (1 << k)]);
                p_nx[i] = p[i] & p[i - (1 << k)];
            end
            g = g_nx;
            p = p_nx;
        end
        s_o  = p0 ^ {g[ADD_W-2:0], 1'b0};
        ca_o = g[ADD_W-1];
    end

endmodule

// File: rtl/adder_rr_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr, wrapping.
// The pointer itself lives in the scheduler.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    input  logic            en_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IDW-1:0]  gnt_idx_o,
    output logic            any_gnt_o
);

    // Scan from the pointer upward and stop at the first asserted request.
    always_comb begin
        int   idx;
        logic found;
        // NOTE: every output gets a default before any branch, so no path leaves one
        // unassigned and no latch is inferred.
        gnt_o     = '0;
        gnt_idx_o = '0;
        any_gnt_o = 1'b0;
        found     = 1'b0;
        for (int off = 0; off < NREQ; off++) begin
            idx = (int'(ptr_i) + off) % NREQ;
            if (!found && req_i[idx]) begin
                found     = 1'b1;
                gnt_idx_o = IDW'(idx);
            end
        end
        if (en_i && found) begin
            gnt_o[gnt_idx_o] = 1'b1;
            any_gnt_o        = 1'b1;
        end
    end

endmodule

// File: rtl/adder_rr_scheduler.sv
// Round-robin scheduler sharing one adder core among NREQ requesters, with a single
// registered operand slot and a valid/ready result port carrying the requester ID.
// Optional build macro ADDER_STATS_EN adds per-requester saturating grant counters.
module adder_rr_scheduler
    import adder_rr_scheduler_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic               clk,
    input  logic               rst,
`ifdef ADDER_STATS_EN
    input  logic [IDW-1:0]     stat_sel,
    input  logic               stat_clr,
    output logic [STAT_W-1:0]  stat_count,
`endif
    adder_rr_scheduler_if.slave bus
);

    slot_state_e      state_q, state_d;
    logic [ADD_W-1:0] op_a_q, op_a_d;
    logic [ADD_W-1:0] op_b_q, op_b_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic             can_accept;
    logic             arb_en;
    logic             accept;
    logic [NREQ-1:0]  gnt;
    logic [IDW-1:0]   gnt_idx;

    // The slot can take a new operand pair when empty or when it drains this cycle.
    assign can_accept = (state_q == ST_EMPTY) | bus.out_ready;
    assign arb_en     = can_accept & ~rst;

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req_i     (bus.req_valid),
        .ptr_i     (ptr_q),
        .en_i      (arb_en),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx),
        .any_gnt_o (accept)
    );

    assign bus.req_ready = gnt;

    // Next state: slot FSM, operand/ID capture and round-robin pointer advance.
    always_comb begin
        state_d = state_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_EMPTY: if (accept) state_d = ST_FULL;
            ST_FULL:  if (bus.out_ready && !accept) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
        if (accept) begin
            op_a_d = bus.req_a[int'(gnt_idx)*ADD_W +: ADD_W];
            op_b_d = bus.req_b[int'(gnt_idx)*ADD_W +: ADD_W];
            id_d   = gnt_idx;
            ptr_d  = (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the operand registers are reset as well, because the sum output is
            // observed straight from them and must read zero out of reset.
            state_q <= ST_EMPTY;
            op_a_q  <= '0;
            op_b_q  <= '0;
            id_q    <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
        end
    end

    rd_adder32 u_core (
        .a_i  (op_a_q),
        .b_i  (op_b_q),
        .s_o  (bus.out_sum),
        .ca_o (bus.out_carry)
    );

    assign bus.out_valid = (state_q == ST_FULL);
    assign bus.out_id    = id_q;

`ifdef ADDER_STATS_EN
    logic [STAT_W-1:0] cnt_q [NREQ];

    // Saturating per-requester grant counters; a clear beats a same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst || stat_clr) begin
            for (int i = 0; i < NREQ; i++) cnt_q[i] <= '0;
        end else if (accept && (cnt_q[gnt_idx] != '1)) begin
            cnt_q[gnt_idx] <= cnt_q[gnt_idx] + 1'b1;
        end
    end

    assign stat_count = cnt_q[stat_sel];
`else
    // This build carries no grant statistics.
`endif

endmodule

// File: tb/tb_adder_rr_scheduler.sv
// Self-checking bench for adder_rr_scheduler: a grant/valid vector table plus
// hand-written reset, single-op, reset-mid-op and (with ADDER_STATS_EN) counter sequences.
// Results are checked against a scoreboard of sums computed from the driven operands.
module tb_adder_rr_scheduler;
    import adder_rr_scheduler_pkg::*;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    adder_rr_scheduler_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

`ifdef ADDER_STATS_EN
    logic [IDW-1:0]    stat_sel;
    logic              stat_clr;
    logic [STAT_W-1:0] stat_count;
`endif

    adder_rr_scheduler #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk        (clk),
        .rst        (rst),
`ifdef ADDER_STATS_EN
        .stat_sel   (stat_sel),
        .stat_clr   (stat_clr),
        .stat_count (stat_count),
`endif
        .bus        (bus)
    );

    typedef struct {
        logic [31:0]    sum;
        logic           carry;
        logic [IDW-1:0] id;
    } res_t;

    typedef struct {
        logic [NREQ-1:0] rv;
        logic            ordy;
        logic [NREQ-1:0] exp_rdy;
        logic            exp_valid;
    } vec_t;

    res_t sb[$];
    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    logic           hold_prev;
    logic [31:0]    hold_sum;
    logic           hold_carry;
    logic [IDW-1:0] hold_id;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [NREQ-1:0] rv, input logic ordy,
                           input logic [NREQ-1:0] rdy, input logic vld);
        vec_t v;
        v.rv = rv; v.ordy = ordy; v.exp_rdy = rdy; v.exp_valid = vld;
        vecs.push_back(v);
    endtask

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
        bus.req_a[i*32 +: 32] = a;
        bus.req_b[i*32 +: 32] = b;
    endtask

    task automatic rand_ops();
        for (int i = 0; i < NREQ; i++) set_op(i, $urandom, $urandom);
    endtask

    // Observe one cycle mid-period: record accepts, check holds and consumed results,
    // then advance to just after the next rising edge.
    task automatic tick();
        res_t r;
        #2;
        for (int i = 0; i < NREQ; i++) begin
            if (bus.req_valid[i] && bus.req_ready[i]) begin
                {r.carry, r.sum} = {1'b0, bus.req_a[i*32 +: 32]} + {1'b0, bus.req_b[i*32 +: 32]};
                r.id = IDW'(i);
                sb.push_back(r);
            end
        end
        if (hold_prev) begin
            check("hold_valid", bus.out_valid, 1);
            check("hold_sum", bus.out_sum, hold_sum);
            check("hold_carry", bus.out_carry, hold_carry);
            check("hold_id", bus.out_id, hold_id);
        end
        if (bus.out_valid && bus.out_ready) begin
            check("sb_has_entry", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                r = sb.pop_front();
                check("res_sum", bus.out_sum, r.sum);
                check("res_carry", bus.out_carry, r.carry);
                check("res_id", bus.out_id, r.id);
            end
        end
        hold_prev  = bus.out_valid & ~bus.out_ready;
        hold_sum   = bus.out_sum;
        hold_carry = bus.out_carry;
        hold_id    = bus.out_id;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        bus.req_valid = '0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        sb.delete();
        hold_prev = 1'b0;
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        bus.req_valid = '0;
        bus.out_ready = 1'b1;
        bus.req_a     = '0;
        bus.req_b     = '0;
        hold_prev     = 1'b0;
`ifdef ADDER_STATS_EN
        stat_sel = 2'd2;
        stat_clr = 1'b0;
`endif

        // Reset for two cycles; requests during reset must not be granted.
        @(posedge clk);
        #1;
        bus.req_valid = '1;
        #2;
        check("ready_in_reset", bus.req_ready, 0);
        @(posedge clk);
        #1;
        bus.req_valid = '0;
        rst = 1'b0;
        #1;
        check("rst_valid", bus.out_valid, 0);
        check("rst_ready", bus.req_ready, 0);
        check("rst_sum", bus.out_sum, 0);
        check("rst_carry", bus.out_carry, 0);
        check("rst_id", bus.out_id, 0);
        tick();

        // Single op from requester 1 wrapping to zero with carry.
        set_op(1, 32'hFFFF_FFFF, 32'h0000_0001);
        bus.req_valid = 4'b0010;
        #1;
        check("single_ready", bus.req_ready, 4'b0010);
        tick();
        bus.req_valid = '0;
        #1;
        check("single_valid", bus.out_valid, 1);
        check("single_sum", bus.out_sum, 32'h0);
        check("single_carry", bus.out_carry, 1);
        check("single_id", bus.out_id, 1);
        tick();
        tick();
        check("drain_valid", bus.out_valid, 0);
        check("drain_sum_kept", bus.out_sum, 32'h0);

        // Vector table: rotation, backpressure, single requester, drop, drain.
        do_reset(1);
        for (int i = 0; i < 8; i++) add_vec(4'b1111, 1'b1, 4'b0001 << (i % 4), i != 0);
        add_vec(4'b0101, 1'b0, 4'b0000, 1'b1);
        add_vec(4'b0101, 1'b0, 4'b0000, 1'b1);
        add_vec(4'b0101, 1'b0, 4'b0000, 1'b1);
        add_vec(4'b0101, 1'b1, 4'b0001, 1'b1);
        add_vec(4'b0101, 1'b1, 4'b0100, 1'b1);
        add_vec(4'b0101, 1'b1, 4'b0001, 1'b1);
        add_vec(4'b0100, 1'b1, 4'b0100, 1'b1);
        add_vec(4'b0100, 1'b1, 4'b0100, 1'b1);
        add_vec(4'b0100, 1'b1, 4'b0100, 1'b1);
        add_vec(4'b0000, 1'b1, 4'b0000, 1'b1);
        add_vec(4'b0000, 1'b1, 4'b0000, 1'b0);
        add_vec(4'b1000, 1'b0, 4'b1000, 1'b0);
        add_vec(4'b1000, 1'b0, 4'b0000, 1'b1);
        add_vec(4'b0000, 1'b1, 4'b0000, 1'b1);
        add_vec(4'b0011, 1'b1, 4'b0001, 1'b0);
        add_vec(4'b0011, 1'b1, 4'b0010, 1'b1);
        add_vec(4'b0000, 1'b1, 4'b0000, 1'b1);
        add_vec(4'b0000, 1'b1, 4'b0000, 1'b0);
        for (int v = 0; v < vecs.size(); v++) begin
            bus.req_valid = vecs[v].rv;
            bus.out_ready = vecs[v].ordy;
            if (v == 0) begin
                for (int i = 0; i < NREQ; i++) set_op(i, 32'h1234_5678, 32'h1111_1111);
            end else begin
                rand_ops();
            end
            #1;
            check($sformatf("vec%0d_ready", v), bus.req_ready, vecs[v].exp_rdy);
            check($sformatf("vec%0d_valid", v), bus.out_valid, vecs[v].exp_valid);
            if (v == 1) begin
                check("fair_sum_const", bus.out_sum, 32'h2345_6789);
                check("fair_carry_const", bus.out_carry, 0);
            end
            tick();
        end

        // Reset while a result is pending: result dropped, pointer back to 0.
        bus.out_ready = 1'b1;
        bus.req_valid = 4'b0010;
        rand_ops();
        tick();
        bus.req_valid = '0;
        bus.out_ready = 1'b0;
        tick();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        hold_prev = 1'b0;
        check("midrst_valid", bus.out_valid, 0);
        bus.req_valid = 4'b0101;
        bus.out_ready = 1'b1;
        rand_ops();
        #1;
        check("midrst_first_grant", bus.req_ready, 4'b0001);
        tick();
        #1;
        check("midrst_second_grant", bus.req_ready, 4'b0100);
        tick();
        bus.req_valid = '0;
        tick();
        tick();
        check("end_valid", bus.out_valid, 0);
        check("sb_drained", sb.size(), 0);

`ifdef ADDER_STATS_EN
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        bus.req_valid = 4'b0100;
        repeat (5) tick();
        bus.req_valid = '0;
        tick();
        check("stat_five", stat_count, 5);
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        check("stat_clear", stat_count, 0);
        bus.req_valid = 4'b0100;
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        bus.req_valid = '0;
        tick();
        check("stat_clr_wins", stat_count, 0);
        bus.req_valid = 4'b0100;
        repeat (65536) tick();
        bus.req_valid = '0;
        tick();
        tick();
        check("stat_saturate", stat_count, 16'hFFFF);
        sb.delete();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
